// File: rtl/instruction_trace_buffer.sv
// Instruction trace capture: tags each fetched instruction with its cycle index inside a
// bounded window and queues it in a FWFT FIFO. Define TRACE_ZERO_FILTER_EN to skip all-zero words.
module instruction_trace_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int MAX_CYCLES  = 1000,
    parameter int CYCLE_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inValid,
    input  logic [DATA_WIDTH-1:0]        instruction,
    input  logic                         outReady,
    output logic                         outValid,
    output logic [DATA_WIDTH-1:0]        outInstruction,
    output logic [CYCLE_WIDTH-1:0]       outCycle,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         done,
    output logic [15:0]                  dropCount
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = CYCLE_WIDTH + DATA_WIDTH;
    localparam logic [CYCLE_WIDTH-1:0] MAX_TAG   = CYCLE_WIDTH'(MAX_CYCLES);
    localparam logic [CYCLE_WIDTH-1:0] CYC_ONE   = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]         DEPTH_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]         CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]         CNT_ZERO  = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W-1:0]       PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [CYCLE_WIDTH-1:0] cyc_r;
    logic [PTR_W:0]         cnt_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [15:0]            drop_r;
    logic                   valid_r;
    logic                   full_r;
    logic                   done_r;
    logic [ENTRY_W-1:0]     head_r;
    logic [ENTRY_W-1:0]     mem_r [DEPTH];

    logic                   filter_pass_s;
    logic                   capture_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   drop_s;
    logic [PTR_W-1:0]       rd_next_s;
    logic [PTR_W:0]         cnt_next_s;
    logic [CYCLE_WIDTH-1:0] cyc_next_s;
    logic [ENTRY_W-1:0]     entry_s;
    logic [ENTRY_W-1:0]     head_next_s;

    // Optional suppression of idle-fetch bubbles before they reach the FIFO.
    always_comb begin
`ifdef TRACE_ZERO_FILTER_EN
        filter_pass_s = (instruction != {DATA_WIDTH{1'b0}});
`else
        filter_pass_s = 1'b1;
`endif
    end

    // Handshake decode; a full FIFO still accepts a push when the head leaves the same cycle.
    always_comb begin
        capture_s = inValid && !done_r && filter_pass_s;
        pop_s     = valid_r && outReady;
        push_s    = capture_s && (!full_r || pop_s);
        drop_s    = capture_s && full_r && !pop_s;
        entry_s   = {cyc_r, instruction};
        if (pop_s) begin
            rd_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_next_s = rd_ptr_r;
        end
        if (cyc_r < MAX_TAG) begin
            cyc_next_s = cyc_r + CYC_ONE;
        end else begin
            cyc_next_s = cyc_r;
        end
    end

    // Occupancy update from the push/pop pair.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   cnt_next_s = cnt_r + CNT_ONE;
            2'b01:   cnt_next_s = cnt_r - CNT_ONE;
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Next head: the word being written when it lands in an otherwise empty FIFO, else storage.
    always_comb begin
        if (cnt_next_s == CNT_ZERO) begin
            head_next_s = head_r;
        end else if (push_s && (rd_next_s == wr_ptr_r)) begin
            head_next_s = entry_s;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_r    <= {CYCLE_WIDTH{1'b0}};
            cnt_r    <= CNT_ZERO;
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            drop_r   <= 16'h0000;
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
            done_r   <= 1'b0;
            head_r   <= {ENTRY_W{1'b0}};
        end else begin
            cyc_r    <= cyc_next_s;
            cnt_r    <= cnt_next_s;
            rd_ptr_r <= rd_next_s;
            valid_r  <= (cnt_next_s != CNT_ZERO);
            full_r   <= (cnt_next_s == DEPTH_CNT);
            done_r   <= (cyc_next_s == MAX_TAG);
            head_r   <= head_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (drop_s && (drop_r != 16'hFFFF)) begin
                drop_r <= drop_r + 16'h0001;
            end
        end
    end

    assign outValid       = valid_r;
    assign outInstruction = head_r[DATA_WIDTH-1:0];
    assign outCycle       = head_r[ENTRY_W-1:DATA_WIDTH];
    assign count          = cnt_r;
    assign full           = full_r;
    assign done           = done_r;
    assign dropCount      = drop_r;

endmodule

// File: tb/tb_instruction_trace_buffer.sv
// Scoreboard bench for instruction_trace_buffer: expected entries are queued as stimulus is
// driven and compared in order as the DUT hands them out.
module tb_instruction_trace_buffer;

    localparam int DW    = 32;
    localparam int CW    = 32;
    localparam int DEPTH = 4;
    localparam int MAXC  = 250;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          inValid = 1'b0;
    logic [DW-1:0] instruction = 32'h0;
    logic          outReady = 1'b0;
    logic          outValid;
    logic [DW-1:0] outInstruction;
    logic [CW-1:0] outCycle;
    logic [2:0]    count;
    logic          full;
    logic          done;
    logic [15:0]   dropCount;

    instruction_trace_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MAX_CYCLES (MAXC),
        .CYCLE_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .inValid       (inValid),
        .instruction   (instruction),
        .outReady      (outReady),
        .outValid      (outValid),
        .outInstruction(outInstruction),
        .outCycle      (outCycle),
        .count         (count),
        .full          (full),
        .done          (done),
        .dropCount     (dropCount)
    );

    always #5 clk = ~clk;

    int            check_cnt = 0;
    int            err_cnt   = 0;
    logic [63:0]   exp_q [$];
    logic [31:0]   m_cyc = 32'd0;
    logic [15:0]   m_drop = 16'd0;
    int            last_tag = -1;
    int            pops = 0;
    int            attempted = 0;

`ifdef TRACE_ZERO_FILTER_EN
    localparam int FILT_EXP = 2;
`else
    localparam int FILT_EXP = 4;
`endif

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit fpass(input logic [31:0] ins);
`ifdef TRACE_ZERO_FILTER_EN
        return ins != 32'h0;
`else
        return 1'b1;
`endif
    endfunction

    // One cycle: drive at the falling edge, compare registered state, advance the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy);
        logic pop;
        logic cap;
        @(negedge clk);
        inValid     = v;
        instruction = ins;
        outReady    = rdy;
        check("out_valid", 64'(outValid), 64'(exp_q.size() != 0));
        check("count", 64'(count), 64'(exp_q.size()));
        check("full", 64'(full), 64'(exp_q.size() == DEPTH));
        check("done", 64'(done), 64'(m_cyc == MAXC));
        check("drop_count", 64'(dropCount), 64'(m_drop));
        pop = (exp_q.size() != 0) && rdy;
        if (pop) begin
            check("head", {outCycle, outInstruction}, exp_q[0]);
            check("tag_order", 64'(int'(outCycle) > last_tag), 64'(1));
            last_tag = int'(outCycle);
            void'(exp_q.pop_front());
            pops++;
        end
        cap = v && (m_cyc < MAXC) && fpass(ins);
        if (cap) begin
            attempted++;
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back({m_cyc, ins});
            end else if (m_drop != 16'hFFFF) begin
                m_drop++;
            end
        end
        if (m_cyc < MAXC) begin
            m_cyc++;
        end
    endtask

    // Reset with live inputs present; those inputs must not be captured.
    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        inValid     = 1'b1;
        instruction = 32'hDEAD_BEEF;
        outReady    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        exp_q.delete();
        m_cyc     = 32'd0;
        m_drop    = 16'd0;
        last_tag  = -1;
        pops      = 0;
        attempted = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && exp_q.size() != 0; i++) begin
            step(1'b0, 32'h0, 1'b1);
        end
        step(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        // Reset values and a three-entry capture with no consumer.
        do_reset();
        check("rst_out_instr", 64'(outInstruction), 64'(0));
        check("rst_out_cycle", 64'(outCycle), 64'(0));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0050_0093, 1'b0);
        end
        step(1'b0, 32'h0, 1'b0);
        check("three_entries", 64'(count), 64'(3));
        drain();

        // Zero-word filter behaviour.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i % 2 == 0) ? 32'h0 : 32'h00A0_0113, 1'b0);
        end
        step(1'b0, 32'h0, 1'b0);
        check("filter_entries", 64'(count), 64'(FILT_EXP));
        check("filter_drops", 64'(dropCount), 64'(0));
        drain();

        // Overflow: drops counted, then push accepted alongside a pop at full.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h1000_0000 + 32'(i), 1'b0);
        end
        step(1'b0, 32'h0, 1'b0);
        check("full_flag", 64'(full), 64'(1));
        check("full_count", 64'(count), 64'(4));
        check("full_drops", 64'(dropCount), 64'(2));
        step(1'b1, 32'h2000_0001, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        check("push_pop_full_count", 64'(count), 64'(4));
        check("push_pop_full_drops", 64'(dropCount), 64'(2));
        drain();

        // Mid-operation reset clears entries, drops and the window.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h3000_0000 + 32'(i), 1'b0);
        end
        do_reset();
        check("rst_mid_count", 64'(count), 64'(0));
        check("rst_mid_valid", 64'(outValid), 64'(0));
        check("rst_mid_drops", 64'(dropCount), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        step(1'b1, 32'h4000_0001, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        check("rst_mid_first_tag", 64'(outCycle), 64'(0));
        drain();

        // Random back-pressure; every attempted capture is either popped or dropped.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(1'b1, $urandom | 32'h1, 1'($urandom_range(0, 1)));
        end
        drain();
        check("pops_plus_drops", 64'(pops + int'(dropCount)), 64'(attempted));

        // Whole window with a free-running consumer, then capture stops at done.
        do_reset();
        for (int i = 0; i < MAXC + 10; i++) begin
            step(1'b1, 32'h5000_0000 + 32'(i), 1'b1);
        end
        drain();
        check("window_pops", 64'(pops), 64'(MAXC));
        check("window_last_tag", 64'(last_tag), 64'(MAXC - 1));
        check("window_done", 64'(done), 64'(1));
        check("window_empty", 64'(count), 64'(0));

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_trace_buffer.md
# instruction_trace_buffer

Synthesisable instruction trace capture unit placed beside the instruction fetch stage.
- Samples the fetched instruction every cycle for a bounded capture window of `MAX_CYCLES` cycles.
- Tags each accepted instruction with its cycle index and stores the pair in a first-word-fall-through FIFO.
- The FIFO is drained through a valid/ready port by a host, UART bridge or testbench.
- Replaces ad-hoc simulation printing with hardware that works on silicon and in simulation alike.

## Interface
- `DATA_WIDTH`, 32, instruction width in bits.
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `MAX_CYCLES`, 1000, capture window length in cycles; ≥1, must fit in `CYCLE_WIDTH`.
- `CYCLE_WIDTH`, 32, width of cycle tag.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `inValid` in 1: `instruction` is meaningful this cycle.
- `instruction` in `DATA_WIDTH`: fetched instruction.
- `outReady` in 1: consumer accepts head entry.
- `outValid` out 1: FIFO non-empty; head entry presented.
- `outInstruction` out `DATA_WIDTH`: head instruction.
- `outCycle` out `CYCLE_WIDTH`: head cycle tag.
- `count` out `$clog2(DEPTH)+1`: entries held.
- `full` out 1: `count == DEPTH`.
- `done` out 1: capture window closed.
- `dropCount` out 16: saturating count of lost captures.

## Operation
- Cycle counter `cyc`:
  - 0 after reset.
  - +1 per cycle while `cyc < MAX_CYCLES`; holds at `MAX_CYCLES`.
  - `done = (cyc == MAX_CYCLES)`.
- Capture condition: `inValid && !done && filter_pass`. The entry written is `{cyc, instruction}` (current, pre-increment value). Captures therefore carry tags 0..`MAX_CYCLES-1`.
- Pop: `outValid && outReady` removes the head; the next entry appears the following cycle.
- Push vs. FIFO state:
  - Not full: capture is pushed.
  - Full with no pop that cycle: capture is dropped and `dropCount` increments, saturating at 0xFFFF.
  - Full with simultaneous pop: push accepted, `count` unchanged.
- Simultaneous push and pop while non-empty: `count` unchanged.
- Empty with push:
  - Entry visible on `outValid` next cycle; no same-cycle bypass.
  - `outReady` is ignored while `outValid` is 0.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- Draining continues after `done`. Only captures stop.
- `outInstruction`/`outCycle` hold their last values when `outValid` is 0; consumers must not rely on them.

## Timing
- Reset values, effective the cycle after `reset` is sampled high:
  - `cyc`=0, `count`=0, pointers=0, `dropCount`=0.
  - `outValid`=0, `full`=0, `done`=0.
  - `outInstruction`=0, `outCycle`=0.
- `reset` mid-operation discards all stored entries and restarts the window. An input presented in the same cycle as `reset` is not captured.
- Capture-to-output latency: 1 cycle into an empty FIFO.
- Throughput: 1 push and 1 pop per cycle.
- `count`, `full`, `outValid` and `done` are registered-state derived, with no combinational path from inputs.
- `outReady` affects only next-state logic; no combinational path to outputs.

## Configuration
- `TRACE_ZERO_FILTER_EN`:
  - Defined: `filter_pass = (instruction != 0)`. All-zero instructions (bubbles/NOPs from an idle fetch) are never captured and never counted as drops.
  - Undefined: `filter_pass = 1`. Every valid instruction is captured, zeros included.

## Test plan
- Reset then `inValid`=1 with `instruction`=0x00500093 for 3 cycles, `outReady`=0 → 3 entries, tags 0,1,2; `outValid` rises 1 cycle after the first push.
- Macro defined, inputs alternating 0x0 and 0x00A00113 for 4 cycles from `cyc`=0 → 2 entries (tags 1,3), `dropCount`=0. Same stimulus without the macro → 4 entries.
- `DEPTH`=4, `outReady`=0, 6 valid nonzero inputs → `full`=1, `count`=4, `dropCount`=2. Then a push with simultaneous pop at full → accepted, `count` stays 4.
- `MAX_CYCLES`=8, continuous valid input → exactly 8 captures (tags 0..7) with `outReady`=1. `done`=1 from cycle 8 onward; no further pushes while draining.
- `reset` asserted with 3 entries stored → next cycle `count`=0, `outValid`=0, `cyc`=0, `dropCount`=0, `done`=0.
- `outReady` random 50%, 200 nonzero inputs, `DEPTH`=16 → pops match pushes in order, with tags strictly increasing. Total pops + `dropCount` equals the number of captures attempted.
